// File: rtl/irq_controller.sv
// irq_controller: memory-mapped controller for up to 32 interrupt sources with edge/level
// select, mask, pending latch, fixed lowest-index priority and a request/ack handshake.
// Define IRQC_SYNC_EN to put a two-flop synchroniser on every srcIn bit.
module irq_controller #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
   parameter int          N_SRC     = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] srcIn,
   input  logic [31:0] inputData,
   input  logic [31:0] inputAddr,
   input  logic        wrEn,
   input  logic [31:0] outputAddr,
   output logic [31:0] outputData,
   output logic [31:0] IRQ
);

   localparam logic [31:0] IMPL_MASK = 32'hFFFF_FFFF >> (32 - N_SRC);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } fsmState_t;

   fsmState_t   stateR, stateNext;
   logic [31:0] pendR, maskR, edgeR, prevR, activeR, irqR;
   logic [31:0] pendNext, activeNext, irqNext;
   logic [31:0] srcS, setBits, ackBits, cand, lowest, rdMux;
   logic [31:0] wrOff, rdOff;
   logic        maskWr, ackWr, edgeWr;

`ifdef IRQC_SYNC_EN
   logic [31:0] sync1R, sync2R;

   // Two-flop synchroniser for asynchronous source pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1R <= 32'h0;
         sync2R <= 32'h0;
      end else begin
         sync1R <= srcIn;
         sync2R <= sync1R;
      end
   end

   assign srcS = sync2R & IMPL_MASK;
`else
   assign srcS = srcIn & IMPL_MASK;
`endif

   assign wrOff  = inputAddr - BASE_ADDR;
   assign rdOff  = outputAddr - BASE_ADDR;
   assign maskWr = wrEn & (wrOff == 32'd1);
   assign ackWr  = wrEn & (wrOff == 32'd2);
   assign edgeWr = wrEn & (wrOff == 32'd3);

   // Set wins over a same-cycle ACK because setBits is OR-ed in after the clear.
   assign ackBits  = ackWr ? inputData : 32'h0;
   assign setBits  = srcS & (~edgeR | ~prevR);
   assign pendNext = ((pendR & ~ackBits) | setBits) & IMPL_MASK;
   assign cand     = pendR & maskR;
   assign lowest   = cand & (~cand + 32'd1);

   // Pending, mask and edge-select registers plus the previous-source flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pendR <= 32'h0;
         maskR <= 32'h0;
         edgeR <= 32'h0;
         prevR <= 32'h0;
      end else begin
         pendR <= pendNext;
         if (maskWr) maskR <= inputData & IMPL_MASK;
         if (edgeWr) edgeR <= inputData & IMPL_MASK;
         // Tracking srcIn every cycle means an EDGE change never sees a stale history.
         prevR <= srcS;
      end
   end

   // Handshake FSM next-state and registered request outputs.
   always_comb begin
      stateNext  = stateR;
      activeNext = activeR;
      irqNext    = irqR;
      case (stateR)
         IDLE: begin
            if (cand != 32'h0) begin
               stateNext  = REQ;
               activeNext = lowest;
               irqNext    = lowest;
            end else begin
               stateNext  = IDLE;
               activeNext = 32'h0;
               irqNext    = 32'h0;
            end
         end
         REQ: begin
            if ((ackBits & activeR) != 32'h0) begin
               stateNext  = GAP;
               activeNext = 32'h0;
               irqNext    = 32'h0;
            end else if (maskWr && ((inputData & activeR) == 32'h0)) begin
               stateNext  = IDLE;
               activeNext = 32'h0;
               irqNext    = 32'h0;
            end else begin
               stateNext  = REQ;
               activeNext = activeR;
               irqNext    = activeR;
            end
         end
         GAP: begin
            stateNext  = IDLE;
            activeNext = 32'h0;
            irqNext    = 32'h0;
         end
         default: begin
            stateNext  = IDLE;
            activeNext = 32'h0;
            irqNext    = 32'h0;
         end
      endcase
   end

   // FSM state, in-service source and request register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateR  <= IDLE;
         activeR <= 32'h0;
         irqR    <= 32'h0;
      end else begin
         stateR  <= stateNext;
         activeR <= activeNext;
         irqR    <= irqNext;
      end
   end

   // Read mux; ACK and out-of-range addresses read as zero.
   always_comb begin
      rdMux = 32'h0;
      case (rdOff)
         32'd0:   rdMux = pendR;
         32'd1:   rdMux = maskR;
         32'd3:   rdMux = edgeR;
         32'd4:   rdMux = activeR;
         default: rdMux = 32'h0;
      endcase
   end

   // Registered read data, one cycle behind outputAddr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outputData <= 32'h0;
      end else begin
         outputData <= rdMux;
      end
   end

   assign IRQ = irqR;

endmodule
